systolic_perf_monitor: RTL and testbench
========================================

# systolic_perf_monitor

Synthesizable, parametrised performance monitor for the systolic array's streaming handshakes. It replaces the bench-only cycle/input/output counting with on-chip hardware. It observes `channels_p` ready/valid channels, for example array input and array output, and keeps the following counters through an armed/run/done window:

- elapsed cycles
- transfers per channel
- stalls per channel
- first-transfer latency per channel

The window ends on explicit stop or on a programmable quiet (drain) timeout. All results are registered outputs; throughput ratios are computed off-chip.

## Interface
- `channels_p`, 2, number of monitored handshake channels
- `ctr_width_p`, 32, width of the cycle, transfer and stall counters
- `lat_width_p`, 16, width of the per-channel first-transfer latency
- `quiet_limit_p`, 200, consecutive transfer-free RUN cycles before auto-DONE; 0 disables auto-DONE
- `clk_i`  in  1  single clock, all logic on its rising edge
- `reset_i`  in  1  synchronous, active-low reset (asserted when 0)
- `en_i`  in  1  global enable; when low, the FSM and all counters hold
- `clear_i`  in  1  return to IDLE and zero all results
- `start_i`  in  1  arm the monitor (IDLE only)
- `stop_i`  in  1  close the window (ARMED/RUN only)
- `valid_i`  in  `channels_p`  per-channel valid
- `ready_i`  in  `channels_p`  per-channel ready (tie to yumi for yumi-style channels)
- `state_o`  out  2  `perf_state_e`
- `cycles_o`  out  `ctr_width_p`  cycles spent in ARMED+RUN
- `xfer_count_o`  out  `channels_p*ctr_width_p`  transfers per channel; channel c occupies bits [c*ctr_width_p +: ctr_width_p]
- `stall_count_o`  out  `channels_p*ctr_width_p`  cycles with valid&!ready, per channel
- `first_lat_o`  out  `channels_p*lat_width_p`  `cycles_o` value at the channel's first transfer
- `first_seen_o`  out  `channels_p`  first transfer latched
- `sat_o`  out  `2*channels_p+1`  sticky saturation flags:
  - bit 0: cycles
  - bits 1..channels_p: transfer counters
  - remaining bits: stall counters

## Operation
- **Definitions**
  - Transfer on channel c: `valid_i[c] & ready_i[c]`.
  - Stall on channel c: `valid_i[c] & ~ready_i[c]`.
- **Counting cycle**: a cycle with `reset_i`=1, `en_i`=1, state ARMED or RUN, `clear_i`=0 and `stop_i`=0.
- **FSM states**
  - IDLE=0
  - ARMED=1
  - RUN=2
  - DONE=3
- **Priority**: reset > `clear_i` > `stop_i` > `start_i`.
- **Transitions**
  - IDLE→ARMED on `start_i`.
  - ARMED→RUN on any transfer in a counting cycle; that transfer is counted.
  - ARMED/RUN→DONE on `stop_i`.
  - RUN→DONE when the quiet counter reaches `quiet_limit_p`.
  - Any state→IDLE on `clear_i`.
  - DONE holds until `clear_i`. `start_i` is ignored outside IDLE.
- **Counting rules** (apply in every counting cycle)
  - `cycles_o` +1.
  - Per-channel transfer and stall counters increment as defined above.
  - On a channel's first transfer, `first_lat_o[c]` takes the pre-increment `cycles_o`, truncated to its low `lat_width_p` bits, and `first_seen_o[c]` is set. Later transfers do not update it.
- **Stop cycle**: a transfer or stall in the cycle where `stop_i` is asserted is not counted.
- **Quiet counter**
  - Counts only RUN counting cycles with no transfer on any channel.
  - Zeroes on any transfer.
  - DONE is entered on the edge ending the `quiet_limit_p`-th consecutive quiet cycle.
- **Saturation**: counters stop at all-ones and never wrap; the matching `sat_o` bit sets and stays set until clear or reset.
- **Clear/reset**: `clear_i` or reset zeroes every output, quiet counter and flag; `state_o`=IDLE.
- **en_i low**: full hold, including the quiet counter. `clear_i` and reset still act.

## Timing
- All outputs are registered and update on the edge after the causing input.
- **Reset value of every output**: 0 (`state_o`=IDLE).
- `start_i` at edge t gives `state_o`=ARMED from t+1; a transfer at t+1+k gives `first_lat_o`=k.
- Results are stable and readable in DONE with no further latency.
- **Reset mid-operation**: outputs are zero on the following edge; no residual state.

## Structure
- **Package `systolic_perf_pkg`**
  - `perf_state_e` enum (2-bit, values above).
  - Localparams for the `sat_o` bit indexing.
  - Quiet-counter width function: `$clog2(quiet_limit_p+1)`, minimum 1.
- **Sub-module `perf_sat_counter`**
  - Parametrised width.
  - Ports: clear, inc, value, sticky sat.
  - Instantiated once for cycles and `2*channels_p` times for transfers and stalls.
- **Top level**: FSM, quiet counter, first-latency capture, output packing.

## Test plan
- **Basic window**
  - Stimulus: `start_i`, then ch0 valid=ready=1 pulses every other cycle from ARMED cycle 3, 64 pulses, then idle.
  - Required: state goes ARMED→RUN at the first pulse and DONE 200 quiet cycles after the last; `xfer0`=64, `first_lat0`=3, `cycles_o`=330, `stall0`=0, `first_seen_o`=01.
- **Stall accounting**
  - Stimulus: ch1 valid held 5 cycles with ready=0, then ready=1 for 1 cycle.
  - Required: `stall1`=5, `xfer1`=1.
- **Saturation**
  - Stimulus: `ctr_width_p`=4, 20 transfers on ch0.
  - Required: `xfer0`=15, `sat_o[1]`=1; after `clear_i`, all zero.
- **Priority**
  - `stop_i` coincident with a transfer → that transfer is not counted, DONE.
  - `clear_i`+`start_i` together → IDLE, all zero.
  - `start_i` in DONE → ignored.
- **Hold and reset**
  - `en_i`=0 for 10 cycles in RUN → all counters and the quiet counter unchanged.
  - `reset_i`=0 mid-RUN → IDLE and all outputs 0 on the next edge.

Source files
------------

// File: rtl/systolic_perf_pkg.sv
// Shared types and sizing helpers for the systolic handshake performance monitor.
// Defines the FSM encoding, saturation-flag bit layout and quiet-counter sizing.
package systolic_perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE  = 2'd0,
    PERF_ARMED = 2'd1,
    PERF_RUN   = 2'd2,
    PERF_DONE  = 2'd3
  } perf_state_e;

  // sat_o layout: cycles, then one bit per transfer counter, then one per stall counter
  localparam int unsigned SAT_CYCLES_BIT = 0;
  localparam int unsigned SAT_XFER_BASE  = 1;

  function automatic int unsigned sat_stall_base(input int unsigned channels);
    return SAT_XFER_BASE + channels;
  endfunction

  function automatic int unsigned quiet_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter: one-cycle registered increment, holds at all-ones, never wraps.
// No backpressure; sticky sat flag raises when the value reaches all-ones, cleared by clear/reset.
module perf_sat_counter #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] value_o,
  output logic               sat_o
);

  localparam logic [width_p-1:0] max_lp = '1;

  always_ff @(posedge clk_i) begin
    if (!reset_i || clear_i) begin
      value_o <= '0;
      sat_o   <= 1'b0;
    end else if (inc_i && (value_o != max_lp)) begin
      value_o <= value_o + width_p'(1);
      if (value_o == (max_lp - width_p'(1))) begin
        sat_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_perf_monitor.sv
// On-chip window monitor for ready/valid channels: cycles, transfers, stalls, first-transfer latency.
// All results registered (one edge after cause); purely observes, never applies backpressure.
module systolic_perf_monitor
  import systolic_perf_pkg::*;
#(
  parameter int unsigned channels_p    = 2,
  parameter int unsigned ctr_width_p   = 32,
  parameter int unsigned lat_width_p   = 16,
  parameter int unsigned quiet_limit_p = 200
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic                              stop_i,
  input  logic [channels_p-1:0]             valid_i,
  input  logic [channels_p-1:0]             ready_i,
  output perf_state_e                       state_o,
  output logic [ctr_width_p-1:0]            cycles_o,
  output logic [channels_p*ctr_width_p-1:0] xfer_count_o,
  output logic [channels_p*ctr_width_p-1:0] stall_count_o,
  output logic [channels_p*lat_width_p-1:0] first_lat_o,
  output logic [channels_p-1:0]             first_seen_o,
  output logic [2*channels_p:0]             sat_o
);

  localparam int unsigned quiet_w_lp    = quiet_width(quiet_limit_p);
  localparam int unsigned stall_base_lp = sat_stall_base(channels_p);

  perf_state_e             state_r, state_n;
  logic [quiet_w_lp-1:0]   quiet_r;
  logic [channels_p-1:0]   xfer, stall;
  logic                    any_xfer, active, counting, quiet_cycle, quiet_hit;

  assign xfer        = valid_i & ready_i;
  assign stall       = valid_i & ~ready_i;
  assign any_xfer    = |xfer;
  assign active      = (state_r == PERF_ARMED) || (state_r == PERF_RUN);
  assign counting    = en_i && active && !clear_i && !stop_i;
  assign quiet_cycle = counting && (state_r == PERF_RUN) && !any_xfer;

  generate
    if (quiet_limit_p == 0) begin : g_no_quiet
      assign quiet_hit = 1'b0;
    end else begin : g_quiet
      // Hit on the cycle that would make the run of quiet cycles reach the limit
      assign quiet_hit = quiet_cycle && (quiet_r == quiet_w_lp'(quiet_limit_p - 1));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= PERF_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    if (clear_i) begin
      state_n = PERF_IDLE;
    end else if (en_i) begin
      case (state_r)
        PERF_IDLE:  if (start_i && !stop_i) state_n = PERF_ARMED;
        PERF_ARMED: begin
          if (stop_i)        state_n = PERF_DONE;
          else if (any_xfer) state_n = PERF_RUN;
        end
        PERF_RUN: begin
          if (stop_i || quiet_hit) state_n = PERF_DONE;
        end
        default:    state_n = state_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i || clear_i) begin
      quiet_r <= '0;
    end else if (counting && (state_r == PERF_RUN)) begin
      if (any_xfer) begin
        quiet_r <= '0;
      end else if (quiet_limit_p != 0) begin
        quiet_r <= quiet_r + quiet_w_lp'(1);
      end
    end
  end

  perf_sat_counter #(.width_p(ctr_width_p)) u_cycles (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (counting),
    .value_o (cycles_o),
    .sat_o   (sat_o[SAT_CYCLES_BIT])
  );

  generate
    for (genvar c = 0; c < channels_p; c++) begin : g_chan
      perf_sat_counter #(.width_p(ctr_width_p)) u_xfer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (counting && xfer[c]),
        .value_o (xfer_count_o[c*ctr_width_p +: ctr_width_p]),
        .sat_o   (sat_o[SAT_XFER_BASE + c])
      );

      perf_sat_counter #(.width_p(ctr_width_p)) u_stall (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (counting && stall[c]),
        .value_o (stall_count_o[c*ctr_width_p +: ctr_width_p]),
        .sat_o   (sat_o[stall_base_lp + c])
      );
    end
  endgenerate

  // Latency is the pre-increment cycle count, so a transfer in ARMED cycle k reports k
  always_ff @(posedge clk_i) begin
    if (!reset_i || clear_i) begin
      first_lat_o  <= '0;
      first_seen_o <= '0;
    end else if (counting) begin
      for (int c = 0; c < channels_p; c++) begin
        if (xfer[c] && !first_seen_o[c]) begin
          first_lat_o[c*lat_width_p +: lat_width_p] <= lat_width_p'(cycles_o);
          first_seen_o[c]                           <= 1'b1;
        end
      end
    end
  end

  assign state_o = state_r;

endmodule

// File: tb/tb_systolic_perf_monitor.sv
// Randomized and directed bench for systolic_perf_monitor against an unbounded-count reference model.
// Two instances share stimulus: default widths, and 4-bit counters to exercise saturation.
module tb_systolic_perf_monitor;
  import systolic_perf_pkg::*;

  localparam int     CH    = 2;
  localparam int     QL    = 200;
  localparam longint MAX_M = 64'hFFFF_FFFF;
  localparam longint MAX_S = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, clr = 1'b0, start = 1'b0, stop = 1'b0;
  logic [CH-1:0] vld = '0, rdy = '0;

  always #5 clk = ~clk;

  perf_state_e   st_m, st_s;
  logic [31:0]   cyc_m;
  logic [3:0]    cyc_s;
  logic [63:0]   xf_m, stl_m;
  logic [7:0]    xf_s, stl_s;
  logic [31:0]   lat_m, lat_s;
  logic [1:0]    seen_m, seen_s;
  logic [4:0]    sat_m, sat_s;

  systolic_perf_monitor #(.channels_p(CH), .ctr_width_p(32), .lat_width_p(16), .quiet_limit_p(QL)) u_main (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .clear_i(clr), .start_i(start), .stop_i(stop),
    .valid_i(vld), .ready_i(rdy), .state_o(st_m), .cycles_o(cyc_m), .xfer_count_o(xf_m),
    .stall_count_o(stl_m), .first_lat_o(lat_m), .first_seen_o(seen_m), .sat_o(sat_m)
  );

  systolic_perf_monitor #(.channels_p(CH), .ctr_width_p(4), .lat_width_p(16), .quiet_limit_p(QL)) u_small (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .clear_i(clr), .start_i(start), .stop_i(stop),
    .valid_i(vld), .ready_i(rdy), .state_o(st_s), .cycles_o(cyc_s), .xfer_count_o(xf_s),
    .stall_count_o(stl_s), .first_lat_o(lat_s), .first_seen_o(seen_s), .sat_o(sat_s)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: true event counts, unbounded; clipping applied only when comparing
  int       m_st;
  longint   m_cyc, m_quiet;
  longint   m_xf[CH], m_stl[CH], m_fc[CH];
  logic [CH-1:0] m_seen;

  function automatic longint clip(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_zero();
    m_st = 0; m_cyc = 0; m_quiet = 0; m_seen = '0;
    for (int c = 0; c < CH; c++) begin m_xf[c] = 0; m_stl[c] = 0; m_fc[c] = 0; end
  endtask

  task automatic model_step();
    bit any;
    any = 0;
    if (!rst_n || clr) model_zero();
    else if (en) begin
      if (m_st == 0) begin
        if (start && !stop) m_st = 1;
      end else if (m_st == 1 || m_st == 2) begin
        if (stop) m_st = 3;
        else begin
          for (int c = 0; c < CH; c++) begin
            if (vld[c] && rdy[c]) begin
              any = 1;
              if (!m_seen[c]) begin m_seen[c] = 1'b1; m_fc[c] = m_cyc; end
              m_xf[c]++;
            end else if (vld[c]) m_stl[c]++;
          end
          m_cyc++;
          if (m_st == 1) begin
            if (any) m_st = 2;
          end else if (any) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == QL) m_st = 3;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [4:0] es_m, es_s;
    es_m = '0; es_s = '0;
    chk("state_m", st_m, m_st);
    chk("state_s", st_s, m_st);
    chk("cyc_m", cyc_m, clip(m_cyc, MAX_M));
    chk("cyc_s", cyc_s, clip(m_cyc, MAX_S));
    es_m[0] = (m_cyc >= MAX_M);
    es_s[0] = (m_cyc >= MAX_S);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("xfer%0d_m", c), xf_m[c*32 +: 32], clip(m_xf[c], MAX_M));
      chk($sformatf("xfer%0d_s", c), xf_s[c*4 +: 4], clip(m_xf[c], MAX_S));
      chk($sformatf("stall%0d_m", c), stl_m[c*32 +: 32], clip(m_stl[c], MAX_M));
      chk($sformatf("stall%0d_s", c), stl_s[c*4 +: 4], clip(m_stl[c], MAX_S));
      chk($sformatf("lat%0d_m", c), lat_m[c*16 +: 16], m_seen[c] ? (clip(m_fc[c], MAX_M) & 64'hFFFF) : 0);
      chk($sformatf("lat%0d_s", c), lat_s[c*16 +: 16], m_seen[c] ? (clip(m_fc[c], MAX_S) & 64'hFFFF) : 0);
      es_m[1+c]    = (m_xf[c] >= MAX_M);
      es_s[1+c]    = (m_xf[c] >= MAX_S);
      es_m[1+CH+c] = (m_stl[c] >= MAX_M);
      es_s[1+CH+c] = (m_stl[c] >= MAX_S);
    end
    chk("seen_m", seen_m, m_seen);
    chk("seen_s", seen_s, m_seen);
    chk("sat_m", sat_m, es_m);
    chk("sat_s", sat_s, es_s);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    model_zero();
    tick(); tick();
    chk("rst_state", st_m, PERF_IDLE);
    chk("rst_cycles", cyc_m, 0);
    chk("rst_sat", sat_m, 0);
    rst_n = 1'b1; en = 1'b1;
    tick();

    // Basic window: ch0 pulses every other cycle from ARMED cycle 3
    do_start();
    chk("basic_armed", st_m, PERF_ARMED);
    repeat (3) tick();
    for (int i = 0; i < 64; i++) begin
      vld[0] = 1'b1; rdy[0] = 1'b1; tick();
      if (i == 0) chk("basic_run", st_m, PERF_RUN);
      vld[0] = 1'b0; rdy[0] = 1'b0; tick();
    end
    repeat (198) tick();
    chk("basic_not_done", st_m, PERF_RUN);
    tick();
    chk("basic_done", st_m, PERF_DONE);
    chk("basic_xfer0", xf_m[31:0], 64);
    chk("basic_lat0", lat_m[15:0], 3);
    chk("basic_cycles", cyc_m, 330);
    chk("basic_stall0", stl_m[31:0], 0);
    chk("basic_seen", seen_m, 2'b01);

    // Stall accounting on ch1
    do_clear(); do_start();
    vld[1] = 1'b1; rdy[1] = 1'b0;
    repeat (5) tick();
    rdy[1] = 1'b1; tick();
    vld[1] = 1'b0; rdy[1] = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stall_stall1", stl_m[63:32], 5);
    chk("stall_xfer1", xf_m[63:32], 1);
    chk("stall_done", st_m, PERF_DONE);

    // Saturation: 20 back-to-back transfers on ch0
    do_clear(); do_start();
    vld[0] = 1'b1; rdy[0] = 1'b1;
    repeat (20) tick();
    vld[0] = 1'b0; rdy[0] = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("sat_xfer0_s", xf_s[3:0], 15);
    chk("sat_flag1_s", sat_s[1], 1);
    chk("sat_xfer0_m", xf_m[31:0], 20);
    do_clear();
    chk("sat_clr_xfer_s", xf_s, 0);
    chk("sat_clr_flags_s", sat_s, 0);
    chk("sat_clr_cyc_s", cyc_s, 0);

    // Priority: stop with a transfer, start in DONE, clear with start
    do_start();
    vld[0] = 1'b1; rdy[0] = 1'b1;
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    vld[0] = 1'b0; rdy[0] = 1'b0;
    chk("prio_stop_xfer", xf_m[31:0], 3);
    chk("prio_stop_done", st_m, PERF_DONE);
    do_start();
    chk("prio_start_done", st_m, PERF_DONE);
    clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
    chk("prio_clr_state", st_m, PERF_IDLE);
    chk("prio_clr_xfer", xf_m, 0);

    // Hold: en low mid-RUN freezes counters and the quiet run
    do_start();
    vld[0] = 1'b1; rdy[0] = 1'b1; repeat (2) tick();
    vld[0] = 1'b0; rdy[0] = 1'b0; repeat (5) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vld = CH'($urandom); rdy = CH'($urandom); tick();
    end
    chk("hold_cycles", cyc_m, 7);
    chk("hold_xfer0", xf_m[31:0], 2);
    en = 1'b1; vld = '0; rdy = '0;
    repeat (194) tick();
    chk("hold_not_done", st_m, PERF_RUN);
    tick();
    chk("hold_done", st_m, PERF_DONE);

    // Reset mid-RUN
    do_clear(); do_start();
    vld[1] = 1'b1; rdy[1] = 1'b1; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vld = '0; rdy = '0;
    chk("rst_mid_state", st_m, PERF_IDLE);
    chk("rst_mid_xfer", xf_m, 0);
    chk("rst_mid_seen", seen_m, 0);

    // Randomized segments with varying traffic density
    for (int seg = 0; seg < 10; seg++) begin
      int dens;
      dens = (seg % 3 == 0) ? 64 : ((seg % 3 == 1) ? 4 : 1);
      for (int i = 0; i < 300; i++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        clr   = ($urandom_range(0, 199) == 0);
        start = ($urandom_range(0, 7) == 0);
        stop  = ($urandom_range(0, 149) == 0);
        en    = ($urandom_range(0, 9) != 0);
        for (int c = 0; c < CH; c++) begin
          vld[c] = ($urandom_range(0, dens - 1) == 0);
          rdy[c] = $urandom_range(0, 1) == 1;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
